mudi_ctrl: RTL and testbench
============================

MUDI_CTRL -- requirements
Module: mudi_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 5: busy cycles after a mult/multu start.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles after a div/divu start.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 E_valid  input  1  E-stage holds a real instruction, not a bubble.
REQ-007 E_isMudi  input  1  E-stage instruction is mult/multu/div/divu/mthi/mtlo.
REQ-008 E_mudiOp  input  3  op code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo.
REQ-009 D_isMudi  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 MUDI_start  output  1  start strobe to the mult/div unit.
REQ-011 MUDI_mudiOp  output  3  op code forwarded to the unit.
REQ-012 isBusy  output  1  unit is occupied by a multi-cycle op.
REQ-013 D_stall  output  1  freeze PC/F/D and insert a bubble into E.
REQ-014 err_collision  output  1  sticky flag: a MUDI op reached E while the unit was busy.
REQ-015 stall_cnt  output  32  count of cycles with D_stall high.

Function
REQ-016 The FSM SHALL have three states: IDLE, MUL, DIV; isBusy = (state != IDLE).
REQ-017 accept = E_valid & E_isMudi & (state == IDLE) & (E_mudiOp <= 5).
- MUDI_start = accept, combinational, same cycle.
- MUDI_mudiOp = E_mudiOp whenever accept is high, else 0.
REQ-018 Op-code transitions out of IDLE, all taken on the accepting posedge:
- Ops 0/1: go to MUL and load the 4-bit down-counter with MUL_CYCLES.
- Ops 2/3: go to DIV and load the counter with DIV_CYCLES.
- Ops 4/5: stay in IDLE and leave the counter unchanged.
REQ-019 In MUL or DIV, the counter SHALL decrement once per cycle; on the edge where it goes from 1 to 0, the FSM returns to IDLE.
- Result: isBusy is high for exactly N cycles after the start cycle.
REQ-020 E_mudiOp values 6 and 7 SHALL be ignored: no start, no state change.
REQ-021 D_stall = D_isMudi & (isBusy | (accept & E_mudiOp <= 3)).
- A back-to-back dependent MUDI instruction therefore stalls from the start cycle onward.
REQ-022 D_stall SHALL deassert combinationally in the first cycle in which isBusy is low and no new multi-cycle op is being accepted.
REQ-023 If E_valid & E_isMudi & isBusy, then:
- MUDI_start stays low and state/counter are unaffected.
- err_collision sets on the next edge and holds until reset.
REQ-024 stall_cnt SHALL increment by 1 on every edge where D_stall is high, and wrap from 0xFFFFFFFF to 0.
REQ-025 When E_valid is low, the E inputs SHALL be ignored entirely.
REQ-026 Simultaneous counter expiry and a new E-stage MUDI op: the op is a collision (state is still busy in that cycle), not an accept.

Reset
REQ-027 Asserting reset at any time, including mid-MUL/DIV, SHALL immediately force the following without waiting for clk:
- state = IDLE, counter = 0, err_collision = 0, stall_cnt = 0.
- isBusy = 0 and MUDI_start = 0 while reset is held.
REQ-028 After reset deasserts, the first accept SHALL behave exactly as in REQ-018.

Verification
REQ-029 mult, then D_isMudi held high: start pulse at cycle 0; isBusy high cycles 1-5; D_stall high cycles 0-5; stall_cnt = 6.
REQ-030 divu with D_isMudi low: isBusy high for 10 cycles; D_stall never asserts; stall_cnt = 0.
REQ-031 mthi then mflo in D: MUDI_start pulses with MUDI_mudiOp = 4; isBusy stays 0; D_stall stays 0.
REQ-032 div started, then E_valid & E_isMudi driven at busy cycle 3: no second start; err_collision = 1 and sticky; DIV still ends after 10 cycles.
REQ-033 reset asserted asynchronously at busy cycle 4 of a div: isBusy and D_stall drop before the next clk edge; all outputs read 0.
REQ-034 stall_cnt preloaded via force to 0xFFFFFFFF, then one stall cycle: stall_cnt = 0.

Source files
------------

// File: rtl/mudi_ctrl.sv
// mudi_ctrl -- issue/stall controller for a multi-cycle mult/div unit.
//
// Accepts MUDI instructions from the E stage. It starts the unit and tracks
// how long the unit stays busy: MUL_CYCLES for mult/multu and DIV_CYCLES for
// div/divu. mthi/mtlo start the unit but do not occupy it. While the unit is
// busy, it stalls a dependent MUDI instruction in D.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   E_valid        E stage holds a real instruction
//   E_isMudi       E instruction is mult/multu/div/divu/mthi/mtlo
//   E_mudiOp[2:0]  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   D_isMudi       D instruction is any MUDI op (incl. mfhi/mflo)
//   MUDI_start     start strobe to the unit (same cycle as accept)
//   MUDI_mudiOp    op code to the unit, 0 when not starting
//   isBusy         unit occupied by a multi-cycle op
//   D_stall        freeze PC/F/D, bubble into E
//   err_collision  sticky: MUDI op reached E while the unit was busy
//   stall_cnt      number of cycles with D_stall high (wraps)
module mudi_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic        E_isMudi,
  input  logic [2:0]  E_mudiOp,
  input  logic        D_isMudi,
  output logic        MUDI_start,
  output logic [2:0]  MUDI_mudiOp,
  output logic        isBusy,
  output logic        D_stall,
  output logic        err_collision,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        e_mudi;
  logic        busy;
  logic        accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    // Gating with reset keeps the start strobe low while reset is held.
    e_mudi = E_valid & E_isMudi & ~reset;
    busy   = (state_q != ST_IDLE);
    accept = e_mudi & ~busy & (E_mudiOp <= 3'd5);

    MUDI_start  = accept;
    MUDI_mudiOp = accept ? E_mudiOp : '0;
    isBusy      = busy;
    D_stall     = D_isMudi & (busy | (accept & (E_mudiOp <= 3'd3)));

    // A MUDI op arriving while busy is dropped and flagged. This includes the
    // expiry cycle, because the state is still MUL/DIV in that cycle.
    if (e_mudi && busy) begin
      err_d = 1'b1;
    end

    if (D_stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (E_mudiOp)
            3'd0, 3'd1: begin
              state_d = ST_MUL;
              cnt_d   = MUL_LOAD;
            end
            3'd2, 3'd3: begin
              state_d = ST_DIV;
              cnt_d   = DIV_LOAD;
            end
            default: ;
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_collision = err_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_mudi_ctrl.sv
module tb_mudi_ctrl;

  logic        clk;
  logic        reset;
  logic        E_valid;
  logic        E_isMudi;
  logic [2:0]  E_mudiOp;
  logic        D_isMudi;
  logic        MUDI_start;
  logic [2:0]  MUDI_mudiOp;
  logic        isBusy;
  logic        D_stall;
  logic        err_collision;
  logic [31:0] stall_cnt;

  mudi_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .E_valid      (E_valid),
    .E_isMudi     (E_isMudi),
    .E_mudiOp     (E_mudiOp),
    .D_isMudi     (D_isMudi),
    .MUDI_start   (MUDI_start),
    .MUDI_mudiOp  (MUDI_mudiOp),
    .isBusy       (isBusy),
    .D_stall      (D_stall),
    .err_collision(err_collision),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       start;
    logic [2:0] op;
    logic       busy;
    logic       stall;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive E/D inputs just after the edge, queue the expected
  // combinational outputs, then pop and compare them mid-cycle.
  task automatic step(input string tag, input logic v, input logic m,
                      input logic [2:0] op, input logic d,
                      input logic e_start, input logic [2:0] e_op,
                      input logic e_busy, input logic e_stall);
    exp_t e;
    exp_t x;
    @(posedge clk);
    #1;
    E_valid  = v;
    E_isMudi = m;
    E_mudiOp = op;
    D_isMudi = d;
    e.tag   = tag;
    e.start = e_start;
    e.op    = e_op;
    e.busy  = e_busy;
    e.stall = e_stall;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    chk({x.tag, ".start"}, {31'd0, MUDI_start}, {31'd0, x.start});
    chk({x.tag, ".op"},    {29'd0, MUDI_mudiOp}, {29'd0, x.op});
    chk({x.tag, ".busy"},  {31'd0, isBusy}, {31'd0, x.busy});
    chk({x.tag, ".stall"}, {31'd0, D_stall}, {31'd0, x.stall});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    E_valid  = 1'b0;
    E_isMudi = 1'b0;
    E_mudiOp = 3'd0;
    D_isMudi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    E_valid  = 1'b0;
    E_isMudi = 1'b0;
    E_mudiOp = 3'd0;
    D_isMudi = 1'b0;

    // Reset state
    #3;
    chk("rst.busy",  {31'd0, isBusy}, 32'd0);
    chk("rst.start", {31'd0, MUDI_start}, 32'd0);
    chk("rst.stall", {31'd0, D_stall}, 32'd0);
    chk("rst.err",   {31'd0, err_collision}, 32'd0);
    chk("rst.cnt",   stall_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("idle", 0, 0, 3'd0, 0, 0, 3'd0, 0, 0);

    // mult with dependent MUDI held in D
    step("mul.c0", 1, 1, 3'd0, 1, 1, 3'd0, 0, 1);
    for (int unsigned i = 1; i <= 5; i++)
      step($sformatf("mul.c%0d", i), 0, 0, 3'd0, 1, 0, 3'd0, 1, 1);
    step("mul.c6", 0, 0, 3'd0, 1, 0, 3'd0, 0, 0);
    chk("mul.stall_cnt", stall_cnt, 32'd6);
    step("mul.c7", 0, 0, 3'd0, 0, 0, 3'd0, 0, 0);

    // divu without a dependent instruction
    apply_reset();
    step("divu.c0", 1, 1, 3'd3, 0, 1, 3'd3, 0, 0);
    for (int unsigned i = 1; i <= 10; i++)
      step($sformatf("divu.c%0d", i), 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    step("divu.c11", 0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
    chk("divu.stall_cnt", stall_cnt, 32'd0);

    // mthi with mflo in D, mtlo, illegal op, bubble
    step("mthi",   1, 1, 3'd4, 1, 1, 3'd4, 0, 0);
    step("mflo.e", 1, 0, 3'd0, 0, 0, 3'd0, 0, 0);
    step("mtlo",   1, 1, 3'd5, 1, 1, 3'd5, 0, 0);
    step("op6",    1, 1, 3'd6, 1, 0, 3'd0, 0, 0);
    step("op7",    1, 1, 3'd7, 0, 0, 3'd0, 0, 0);
    step("bubble", 0, 1, 3'd0, 1, 0, 3'd0, 0, 0);
    step("post",   0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
    chk("mt.stall_cnt", stall_cnt, 32'd0);
    chk("mt.err", {31'd0, err_collision}, 32'd0);

    // div with collisions at busy cycle 3 and on the expiry cycle
    apply_reset();
    step("col.c0", 1, 1, 3'd2, 0, 1, 3'd2, 0, 0);
    step("col.c1", 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    step("col.c2", 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    chk("col.err_pre", {31'd0, err_collision}, 32'd0);
    step("col.c3", 1, 1, 3'd0, 0, 0, 3'd0, 1, 0);
    step("col.c4", 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    chk("col.err_set", {31'd0, err_collision}, 32'd1);
    step("col.c5", 0, 0, 3'd0, 1, 0, 3'd0, 1, 1);
    for (int unsigned i = 6; i <= 9; i++)
      step($sformatf("col.c%0d", i), 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    step("col.c10", 1, 1, 3'd1, 0, 0, 3'd0, 1, 0);
    step("col.c11", 0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
    step("col.c12", 0, 0, 3'd0, 0, 0, 3'd0, 0, 0);
    chk("col.err_sticky", {31'd0, err_collision}, 32'd1);
    chk("col.stall_cnt", stall_cnt, 32'd1);

    // Asynchronous reset at busy cycle 4 of a div
    step("ar.c0", 1, 1, 3'd2, 1, 1, 3'd2, 0, 1);
    for (int unsigned i = 1; i <= 3; i++)
      step($sformatf("ar.c%0d", i), 0, 0, 3'd0, 1, 0, 3'd0, 1, 1);
    @(posedge clk);
    #1;
    E_valid  = 1'b0;
    E_isMudi = 1'b0;
    D_isMudi = 1'b1;
    #1;
    chk("ar.busy_pre",  {31'd0, isBusy}, 32'd1);
    chk("ar.stall_pre", {31'd0, D_stall}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar.busy",  {31'd0, isBusy}, 32'd0);
    chk("ar.stall", {31'd0, D_stall}, 32'd0);
    chk("ar.start", {31'd0, MUDI_start}, 32'd0);
    chk("ar.op",    {29'd0, MUDI_mudiOp}, 32'd0);
    chk("ar.err",   {31'd0, err_collision}, 32'd0);
    chk("ar.cnt",   stall_cnt, 32'd0);
    @(negedge clk);
    D_isMudi = 1'b0;
    reset    = 1'b0;

    // First accept after reset
    step("par.c0", 1, 1, 3'd1, 0, 1, 3'd1, 0, 0);
    for (int unsigned i = 1; i <= 5; i++)
      step($sformatf("par.c%0d", i), 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    step("par.c6", 0, 0, 3'd0, 0, 0, 3'd0, 0, 0);

    // stall_cnt wrap
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    chk("wrap.pre", stall_cnt, 32'hFFFF_FFFF);
    step("wrap.c0", 1, 1, 3'd0, 1, 1, 3'd0, 0, 1);
    step("wrap.c1", 0, 0, 3'd0, 0, 0, 3'd0, 1, 0);
    chk("wrap.cnt", stall_cnt, 32'd0);
    for (int unsigned i = 2; i <= 6; i++)
      step($sformatf("wrap.c%0d", i), 0, 0, 3'd0, 0, 0, 3'd0, (i <= 5) ? 1'b1 : 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
